nc_host_bridge: RTL and testbench
=================================

// Module: nc_host_bridge
// PURPOSE
// - Chip-side responder for the host byte protocol driven onto the tt_um_neurocore pins by the bench or an external MCU.
// - Accepts command bytes over a 4-phase strobe/ack handshake.
// - Turns them into single-cycle write/read requests to the neuron weight/state array.
// - Returns read data to the pins. Sits between the pin muxing in tt_um_neurocore and the core array.
// PARAMETERS
// - ADDR_W      6   array address width; low ADDR_W bits of the address byte, upper bits ignored
// - RD_TIMEOUT  15  cycles to wait for rd_valid_i before aborting a read
// PORTS
// - clk          in   1       clock; single clock domain
// - rst_n        in   1       asynchronous, active-low reset
// - host_data_i  in   8       command/address/data byte from pins; held stable while strobe high
// - host_stb_i   in   1       host strobe, asynchronous to clk
// - host_par_i   in   1       odd parity over host_data_i; used only with NC_BRIDGE_PARITY_EN
// - host_ack_o   out  1       handshake acknowledge
// - host_rdata_o out  8       read result; valid while host_ack_o high after a READ address byte
// - wr_en_o      out  1       one-cycle array write pulse
// - wr_addr_o    out  ADDR_W  write address
// - wr_data_o    out  8       write data
// - rd_en_o      out  1       one-cycle array read request
// - rd_addr_o    out  ADDR_W  read address
// - rd_data_i    in   8       array read data
// - rd_valid_i   in   1       rd_data_i valid this cycle
// - busy_o       out  1       high whenever state != IDLE
// - err_o        out  1       sticky error flag
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; sync flops reset to 0; edge-detector prev flop reset to 1.
// - Consequence: strobe already high at reset release is not a byte.
// - host_stb_i passes through a 2-FF synchronizer to give stb_s. Byte accepted on stb_s 0->1, only while host_ack_o=0.
// - Accept cycle N: data latched at N; host_ack_o high from N+1 (reads: see RD_WAIT); ack drops 1 cycle after stb_s falls.
// - Opcode byte bits [7:6]: 00 NOP, 01 WRITE, 10 READ, 11 reserved.
// - Reserved opcode sets err_o and stays in IDLE. Any valid opcode clears err_o.
// - FSM:
//   - IDLE: opcode; WRITE -> W_ADDR; READ -> R_ADDR; NOP -> IDLE.
//   - W_ADDR: latch addr -> W_DATA.
//   - W_DATA: latch data; wr_en_o=1 at N+1 with wr_addr_o/wr_data_o -> IDLE.
//   - R_ADDR: latch addr; rd_en_o=1 at N+1 -> RD_WAIT; ack withheld.
//   - RD_WAIT: on rd_valid_i, capture rd_data_i to host_rdata_o and raise ack next cycle -> IDLE.
//     - rd_valid_i coincident with the rd_en_o cycle is accepted.
//     - Timeout after RD_TIMEOUT cycles: host_rdata_o=8'hEE, err_o=1, ack raised, -> IDLE.
// - host_rdata_o holds its value until the next READ completes.
// - Reset mid-command: partial command discarded; no wr_en_o/rd_en_o issued.
// - A stb_s rise while ack high, or during RD_WAIT, is ignored; no byte accepted.
// CONFIGURATION
// - NC_BRIDGE_PARITY_EN defined: each accepted byte checked against host_par_i (odd parity).
//   - Mismatch: err_o=1, byte still acked, FSM -> IDLE, no array access.
// - Not defined: host_par_i ignored; no parity logic.
// STRUCTURE
// - nc_pkg: opcode constants (OP_NOP/OP_WRITE/OP_READ), bridge state enum, RD_ERR_BYTE=8'hEE.
// - Sub-module nc_sync2: 2-FF synchronizer with async active-low reset and a reset-value parameter.
// TESTING
// - WRITE 0x40,0x05,0x3C -> single wr_en_o pulse, wr_addr_o=5, wr_data_o=8'h3C; ack toggles 3 times.
// - READ 0x80,0x07; model returns 8'hA5 after 2 cycles -> rd_addr_o=7, host_rdata_o=8'hA5 with ack.
// - READ with rd_valid_i never asserted -> after 15 cycles host_rdata_o=8'hEE, err_o=1; next NOP clears err_o.
// - Opcode 0xC0 -> err_o=1, no array access; then WRITE succeeds normally.
// - rst_n low after WRITE addr byte; resume after release -> no wr_en_o; a strobe held high at release is not accepted.
// - PARITY_EN: data byte with bad parity -> err_o=1, ack given, no wr_en_o.

Source files
------------

// File: rtl/nc_pkg.sv
// Shared constants for the neurocore host bridge: opcode field values,
// bridge FSM state encoding and the byte returned on an aborted read.
package nc_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [7:0] RD_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_ADDR  = 3'd1,
    ST_W_DATA  = 3'd2,
    ST_R_ADDR  = 3'd3,
    ST_RD_WAIT = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/nc_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module nc_sync2 #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nc_host_bridge.sv
// Host byte-protocol responder: 4-phase strobe/ack bytes in, single-cycle array
// write/read requests out. Optional odd-parity check under NC_BRIDGE_PARITY_EN.
module nc_host_bridge
  import nc_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        host_data_i,
  input  logic              host_stb_i,
  input  logic              host_par_i,
  output logic              host_ack_o,
  output logic [7:0]        host_rdata_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  input  logic              rd_valid_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  bridge_state_e    state;
  logic             stb_s;
  logic             stb_prev;
  logic [1:0]       settle;
  logic             accept;
  logic             par_bad;
  logic [CNT_W-1:0] rd_cnt;

  nc_sync2 #(.RESET_VAL(1'b0)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (host_stb_i),
    .q     (stb_s)
  );

  // stb_prev is pinned high until the synchronizer has flushed, so a strobe
  // already high at reset release never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle   <= 2'b00;
      stb_prev <= 1'b1;
    end else begin
      settle   <= {settle[0], 1'b1};
      stb_prev <= settle[1] ? stb_s : 1'b1;
    end
  end

  assign accept = stb_s && !stb_prev && !host_ack_o && (state != ST_RD_WAIT);

`ifdef NC_BRIDGE_PARITY_EN
  assign par_bad = ~(^{host_data_i, host_par_i});
`else
  logic unused_par;
  assign unused_par = host_par_i;
  assign par_bad    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      host_ack_o   <= 1'b0;
      host_rdata_o <= 8'h00;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= 8'h00;
      rd_en_o      <= 1'b0;
      rd_addr_o    <= '0;
      err_o        <= 1'b0;
      rd_cnt       <= '0;
    end else begin
      wr_en_o <= 1'b0;
      rd_en_o <= 1'b0;
      if (host_ack_o && !stb_s) host_ack_o <= 1'b0;

      if (accept) begin
        if (par_bad) begin
          err_o      <= 1'b1;
          host_ack_o <= 1'b1;
          state      <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              host_ack_o <= 1'b1;
              err_o      <= (host_data_i[7:6] == OP_RSVD);
              if (host_data_i[7:6] == OP_WRITE)     state <= ST_W_ADDR;
              else if (host_data_i[7:6] == OP_READ) state <= ST_R_ADDR;
              else                                  state <= ST_IDLE;
            end
            ST_W_ADDR: begin
              host_ack_o <= 1'b1;
              wr_addr_o  <= host_data_i[ADDR_W-1:0];
              state      <= ST_W_DATA;
            end
            ST_W_DATA: begin
              host_ack_o <= 1'b1;
              wr_data_o  <= host_data_i;
              wr_en_o    <= 1'b1;
              state      <= ST_IDLE;
            end
            ST_R_ADDR: begin
              // Ack is withheld here; it is raised when the read completes.
              rd_addr_o <= host_data_i[ADDR_W-1:0];
              rd_en_o   <= 1'b1;
              rd_cnt    <= '0;
              state     <= ST_RD_WAIT;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end else if (state == ST_RD_WAIT) begin
        if (rd_valid_i) begin
          host_rdata_o <= rd_data_i;
          host_ack_o   <= 1'b1;
          state        <= ST_IDLE;
        end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
          host_rdata_o <= RD_ERR_BYTE;
          err_o        <= 1'b1;
          host_ack_o   <= 1'b1;
          state        <= ST_IDLE;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign busy_o    = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_nc_host_bridge.sv
// Directed scoreboard bench for nc_host_bridge: byte driver, array responder,
// and a negedge monitor that checks writes, reads and every ack against queues.
module tb_nc_host_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] host_data;
  logic       host_stb;
  logic       host_par;
  logic       host_ack_o;
  logic [7:0] host_rdata_o;
  logic       wr_en_o;
  logic [5:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       rd_en_o;
  logic [5:0] rd_addr_o;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy_o;
  logic       err_o;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [13:0] wr_q[$];   // {addr, data}
  logic [5:0]  rd_q[$];   // addr
  logic [8:0]  ack_q[$];  // {rdata, err} seen on each ack rise

  logic [7:0] mem [64];
  int         rd_lat;
  logic [7:0] exp_rdata;

  always #5 clk = ~clk;

  nc_host_bridge #(.ADDR_W(6), .RD_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_data_i  (host_data),
    .host_stb_i   (host_stb),
    .host_par_i   (host_par),
    .host_ack_o   (host_ack_o),
    .host_rdata_o (host_rdata_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data),
    .rd_valid_i   (rd_valid),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One 4-phase transfer; bad_par flips the parity bit.
  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    int n;
    @(negedge clk);
    host_data = b;
    host_par  = ~(^b) ^ bad_par;
    @(negedge clk);
    host_stb = 1'b1;
    n = 0;
    while (!host_ack_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail("ack_rise");
    host_stb = 1'b0;
    n = 0;
    while (host_ack_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("ack_fall");
  endtask

  task automatic exp_ack(input logic err);
    ack_q.push_back({exp_rdata, err});
  endtask

  // Array model: answers rd_en_o after rd_lat cycles (0 = same cycle, <0 = never).
  initial begin
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_en_o && rd_lat >= 0) begin
        repeat (rd_lat) @(negedge clk);
        rd_data  = mem[rd_addr_o];
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic ack_prev;
    logic [13:0] w;
    logic [8:0]  a;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_en_o) begin
        if (wr_q.size() == 0) check("unexpected_wr", {wr_addr_o, wr_data_o}, 14'h3fff ^ {wr_addr_o, wr_data_o});
        else begin
          w = wr_q.pop_front();
          check("wr_addr", wr_addr_o, w[13:8]);
          check("wr_data", wr_data_o, w[7:0]);
        end
      end
      if (rd_en_o) begin
        if (rd_q.size() == 0) check("unexpected_rd", rd_addr_o, ~rd_addr_o);
        else check("rd_addr", rd_addr_o, rd_q.pop_front());
      end
      if (host_ack_o && !ack_prev) begin
        if (ack_q.size() == 0) check("unexpected_ack", host_ack_o, 1'b0);
        else begin
          a = ack_q.pop_front();
          check("ack_rdata", host_rdata_o, a[8:1]);
          check("ack_err", err_o, a[0]);
        end
      end
      ack_prev = host_ack_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Clock/reset and directed stimulus
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    mem[7]    = 8'hA5;
    mem[18]   = 8'h5A;
    rd_lat    = 2;
    exp_rdata = 8'h00;
    host_data = 8'h00;
    host_stb  = 1'b0;
    host_par  = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {host_ack_o, host_rdata_o, wr_en_o, wr_addr_o, wr_data_o,
                            rd_en_o, rd_addr_o, busy_o, err_o}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_state", {busy_o, state_dbg}, 4'h0);

    // WRITE 5 <= 0x3C
    exp_ack(1'b0); send_byte(8'h40, 1'b0);
    exp_ack(1'b0); send_byte(8'h05, 1'b0);
    wr_q.push_back({6'd5, 8'h3C});
    exp_ack(1'b0); send_byte(8'h3C, 1'b0);

    // READ 7, data after 2 cycles
    exp_ack(1'b0); send_byte(8'h80, 1'b0);
    rd_q.push_back(6'd7);
    exp_rdata = 8'hA5;
    exp_ack(1'b0); send_byte(8'h07, 1'b0);

    // READ with upper address bits set and same-cycle rd_valid
    rd_lat = 0;
    exp_ack(1'b0); send_byte(8'h80, 1'b0);
    rd_q.push_back(6'd18);
    exp_rdata = 8'h5A;
    exp_ack(1'b0); send_byte(8'hD2, 1'b0);

    // READ that never completes -> 0xEE and err
    rd_lat = -1;
    exp_ack(1'b0); send_byte(8'h80, 1'b0);
    rd_q.push_back(6'd3);
    exp_rdata = 8'hEE;
    exp_ack(1'b1); send_byte(8'h03, 1'b0);
    exp_ack(1'b0); send_byte(8'h00, 1'b0);

    // Reserved opcode, then a write with don't-care opcode low bits
    exp_ack(1'b1); send_byte(8'hC0, 1'b0);
    exp_ack(1'b0); send_byte(8'h7F, 1'b0);
    exp_ack(1'b0); send_byte(8'hFF, 1'b0);
    wr_q.push_back({6'h3F, 8'h00});
    exp_ack(1'b0); send_byte(8'h00, 1'b0);

    // Reset between address and data byte, strobe held high across release
    exp_ack(1'b0); send_byte(8'h40, 1'b0);
    exp_ack(1'b0); send_byte(8'h05, 1'b0);
    @(negedge clk);
    host_data = 8'h3C;
    host_par  = ~(^8'h3C);
    host_stb  = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 8'h00;
    repeat (10) @(negedge clk);
    check("held_stb_no_ack", {host_ack_o, busy_o, err_o}, 3'b000);
    host_stb = 1'b0;
    repeat (5) @(negedge clk);

    exp_ack(1'b0); send_byte(8'h40, 1'b0);
    exp_ack(1'b0); send_byte(8'h2A, 1'b0);
    wr_q.push_back({6'h2A, 8'h99});
    exp_ack(1'b0); send_byte(8'h99, 1'b0);

`ifdef NC_BRIDGE_PARITY_EN
    exp_ack(1'b0); send_byte(8'h40, 1'b0);
    exp_ack(1'b0); send_byte(8'h05, 1'b0);
    exp_ack(1'b1); send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("parity_back_to_idle", busy_o, 1'b0);
`endif

    repeat (10) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
